// File: rtl/game_pkg.sv
// Shared types for the two-player turn arbiter in front of the maze game FSM.
//   dir_t        : direction pad / move vector, [3]=N [2]=S [1]=E [0]=W
//   DIR_*        : bit positions inside dir_t
//   arb_state_t  : turn arbiter FSM states
//   is_one_hot() : true when exactly one direction bit is set
package game_pkg;

  typedef logic [3:0] dir_t;

  localparam int unsigned DIR_N = 3;
  localparam int unsigned DIR_S = 2;
  localparam int unsigned DIR_E = 1;
  localparam int unsigned DIR_W = 0;

  typedef enum logic [1:0] {
    WAIT_MOVE,
    ISSUE,
    WAIT_RESULT,
    OVER
  } arb_state_t;

  function automatic logic is_one_hot(dir_t v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/game_turn_arbiter_if.sv
// Pad / game-FSM bundle of the turn arbiter.
//   master : drives the pads (p0_dir, p1_dir) and game status (d, win), observes the rest
//   slave  : the arbiter; receives pads and status, drives moves, turn and flags
interface game_turn_arbiter_if #(
  parameter int unsigned MOVE_CNT_W = 8
);
  import game_pkg::*;

  dir_t                  p0_dir;
  dir_t                  p1_dir;
  logic                  d;
  logic                  win;
  logic                  n;
  logic                  s;
  logic                  e;
  logic                  w;
  logic                  turn;
  logic [MOVE_CNT_W-1:0] move_count;
  logic                  invalid;
  logic                  timeout;
  logic                  game_over;
  logic                  winner;

  modport master (
    output p0_dir, p1_dir, d, win,
    input  n, s, e, w, turn, move_count, invalid, timeout, game_over, winner
  );

  modport slave (
    input  p0_dir, p1_dir, d, win,
    output n, s, e, w, turn, move_count, invalid, timeout, game_over, winner
  );

endinterface

// File: rtl/game_dir_edge.sv
// Rising-edge detector for one direction pad.
//   clock, R_n : clock and asynchronous active-low reset
//   raw        : raw held pad level
//   press      : bits that rose since the previous cycle (one press per hold, no repeat)
//   one_hot    : exactly one bit of press set
//   multi      : two or more bits of press set
module game_dir_edge
  import game_pkg::*;
(
  input  logic clock,
  input  logic R_n,
  input  dir_t raw,
  output dir_t press,
  output logic one_hot,
  output logic multi
);

  dir_t prev_q;

  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= raw;
    end
  end

  assign press   = raw & ~prev_q;
  assign one_hot = is_one_hot(press);
  assign multi   = (press != 4'd0) && !one_hot;

endmodule

// File: rtl/game_turn_arbiter.sv
// Two-player turn controller sharing the game's single n/s/e/w move input.
//   clock, R_n : clock and asynchronous active-low reset
//   bus        : pads and game status in; move pulses, turn, move_count, invalid,
//                timeout, game_over and winner out (all outputs are flop outputs)
module game_turn_arbiter
  import game_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 16,
  parameter int unsigned MOVE_CNT_W   = 8
) (
  input logic           clock,
  input logic           R_n,
  game_turn_arbiter_if.slave bus
);

  localparam int unsigned TcntW = $clog2(TURN_TIMEOUT);
  localparam logic [TcntW-1:0] TcntMax = TcntW'(TURN_TIMEOUT - 1);
  localparam logic [MOVE_CNT_W-1:0] CntMax = '1;

  dir_t press0, press1, act_press;
  logic one_hot0, one_hot1, multi0, multi1, act_one_hot, act_multi;

  game_dir_edge u_edge_p0 (
    .clock   (clock),
    .R_n     (R_n),
    .raw     (bus.p0_dir),
    .press   (press0),
    .one_hot (one_hot0),
    .multi   (multi0)
  );

  game_dir_edge u_edge_p1 (
    .clock   (clock),
    .R_n     (R_n),
    .raw     (bus.p1_dir),
    .press   (press1),
    .one_hot (one_hot1),
    .multi   (multi1)
  );

  arb_state_t            state_q, state_d;
  logic [TcntW-1:0]      tcnt_q, tcnt_d;
  dir_t                  move_q, move_d;
  logic                  turn_q, turn_d;
  logic [MOVE_CNT_W-1:0] count_q, count_d;
  logic                  invalid_q, invalid_d;
  logic                  timeout_q, timeout_d;
  logic                  over_q, over_d;
  logic                  winner_q, winner_d;

  // Only the active player's presses reach the FSM.
  assign act_press   = turn_q ? press1 : press0;
  assign act_one_hot = turn_q ? one_hot1 : one_hot0;
  assign act_multi   = turn_q ? multi1 : multi0;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    move_d    = '0;
    turn_d    = turn_q;
    count_d   = count_q;
    invalid_d = 1'b0;
    timeout_d = 1'b0;
    over_d    = over_q;
    winner_d  = winner_q;

    if (state_q != OVER && (bus.d || bus.win)) begin
      state_d = OVER;
      over_d  = 1'b1;
      if (bus.win) begin
        winner_d = turn_q;
      end
    end else begin
      unique case (state_q)
        WAIT_MOVE: begin
          // Wraps at the limit so an invalid press on the last cycle restarts the window.
          tcnt_d = (tcnt_q == TcntMax) ? '0 : tcnt_q + 1'b1;
          if (act_one_hot) begin
            move_d  = act_press;
            state_d = ISSUE;
            if (count_q != CntMax) begin
              count_d = count_q + 1'b1;
            end
          end else if (act_multi) begin
            invalid_d = 1'b1;
          end else if (tcnt_q == TcntMax) begin
            timeout_d = 1'b1;
            turn_d    = ~turn_q;
          end
        end
        ISSUE: begin
          state_d = WAIT_RESULT;
        end
        WAIT_RESULT: begin
          turn_d  = ~turn_q;
          tcnt_d  = '0;
          state_d = WAIT_MOVE;
        end
        OVER: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) begin
      state_q   <= WAIT_MOVE;
      tcnt_q    <= '0;
      move_q    <= '0;
      turn_q    <= 1'b0;
      count_q   <= '0;
      invalid_q <= 1'b0;
      timeout_q <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      move_q    <= move_d;
      turn_q    <= turn_d;
      count_q   <= count_d;
      invalid_q <= invalid_d;
      timeout_q <= timeout_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
    end
  end

  assign bus.n          = move_q[DIR_N];
  assign bus.s          = move_q[DIR_S];
  assign bus.e          = move_q[DIR_E];
  assign bus.w          = move_q[DIR_W];
  assign bus.turn       = turn_q;
  assign bus.move_count = count_q;
  assign bus.invalid    = invalid_q;
  assign bus.timeout    = timeout_q;
  assign bus.game_over  = over_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_game_turn_arbiter.sv
module tb_game_turn_arbiter;

  logic clock;
  logic R_n;

  game_turn_arbiter_if #(.MOVE_CNT_W(8)) bus ();

  game_turn_arbiter #(
    .TURN_TIMEOUT (16),
    .MOVE_CNT_W   (8)
  ) dut (
    .clock (clock),
    .R_n   (R_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state: turn bookkeeping in plain integers.
  logic [3:0] mprev0 = '0, mprev1 = '0, m_pulse = '0;
  bit m_over = 0, m_winseen = 0, m_winner = 0, m_turn = 0, m_inv = 0, m_to = 0;
  int m_count = 0;  // moves issued, saturating at 255
  int m_idle  = 0;  // idle cycles spent waiting in the current turn
  int m_busy  = 0;  // cycles left until the issued move hands the turn over

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task model_reset();
    mprev0 = '0; mprev1 = '0; m_pulse = '0;
    m_over = 0; m_winseen = 0; m_winner = 0; m_turn = 0; m_inv = 0; m_to = 0;
    m_count = 0; m_idle = 0; m_busy = 0;
  endtask

  task model_step();
    logic [3:0] pr0, pr1, act;
    pr0 = bus.p0_dir & ~mprev0;
    pr1 = bus.p1_dir & ~mprev1;
    mprev0 = bus.p0_dir;
    mprev1 = bus.p1_dir;
    act = m_turn ? pr1 : pr0;
    m_pulse = '0; m_inv = 0; m_to = 0;
    if (m_over) begin
    end else if (bus.d || bus.win) begin
      m_over = 1;
      if (bus.win) begin
        m_winseen = 1;
        m_winner  = m_turn;
      end
    end else if (m_busy == 2) begin
      m_busy = 1;
    end else if (m_busy == 1) begin
      m_busy = 0;
      m_turn = !m_turn;
      m_idle = 0;
    end else if ($countones(act) == 1) begin
      m_pulse = act;
      m_busy  = 2;
      if (m_count < 255) m_count++;
    end else if (act != 0) begin
      m_inv  = 1;
      m_idle = (m_idle + 1) % 16;
    end else if (m_idle == 15) begin
      m_to   = 1;
      m_turn = !m_turn;
      m_idle = 0;
    end else begin
      m_idle++;
    end
  endtask

  // Model update on every edge, compare of all outputs shortly after.
  always @(posedge clock or negedge R_n) begin
    if (!R_n) model_reset();
    else model_step();
    #2;
    chk("nsew", {bus.n, bus.s, bus.e, bus.w}, m_pulse);
    chk("turn", bus.turn, m_turn);
    chk("move_count", bus.move_count, m_count);
    chk("invalid", bus.invalid, m_inv);
    chk("timeout", bus.timeout, m_to);
    chk("game_over", bus.game_over, m_over);
    if (m_over && m_winseen) chk("winner", bus.winner, m_winner);
  end

  task automatic press_active(logic [3:0] v);
    if (m_turn) bus.p1_dir = v;
    else bus.p0_dir = v;
  endtask

  int over_wait;
  int r;

  initial begin
    R_n = 1'b0;
    bus.p0_dir = '0; bus.p1_dir = '0; bus.d = 1'b0; bus.win = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_nsew", {bus.n, bus.s, bus.e, bus.w}, 4'b0000);
    chk("rst_turn", bus.turn, 0);
    chk("rst_count", bus.move_count, 0);
    chk("rst_over", bus.game_over, 0);
    R_n = 1'b1;

    // Held north press gives a single pulse.
    bus.p0_dir = 4'b1000;
    @(negedge clock);
    chk("t1_n", {bus.n, bus.s, bus.e, bus.w}, 4'b1000);
    chk("t1_count", bus.move_count, 1);
    @(negedge clock);
    chk("t1_n_off", {bus.n, bus.s, bus.e, bus.w}, 4'b0000);
    chk("t1_turn_hold", bus.turn, 0);
    @(negedge clock);
    chk("t1_turn", bus.turn, 1);
    repeat (2) @(negedge clock);
    bus.p0_dir = '0;
    chk("t1_count_hold", bus.move_count, 1);

    // Player 1 moves west, then turn-0 filtering and invalid press.
    bus.p1_dir = 4'b0001;
    @(negedge clock);
    chk("t2_p1_w", {bus.n, bus.s, bus.e, bus.w}, 4'b0001);
    bus.p1_dir = '0;
    repeat (2) @(negedge clock);
    chk("t2_turn0", bus.turn, 0);
    bus.p1_dir = 4'b0010;
    @(negedge clock);
    chk("t2_p1_drop", {bus.n, bus.s, bus.e, bus.w}, 4'b0000);
    bus.p1_dir = '0;
    bus.p0_dir = 4'b1100;
    @(negedge clock);
    chk("t2_invalid", bus.invalid, 1);
    chk("t2_inv_nomove", {bus.n, bus.s, bus.e, bus.w}, 4'b0000);
    bus.p0_dir = '0;
    @(negedge clock);
    chk("t2_invalid_off", bus.invalid, 0);
    chk("t2_turn_kept", bus.turn, 0);
    bus.p0_dir = 4'b0001;
    @(negedge clock);
    chk("t2_w", {bus.n, bus.s, bus.e, bus.w}, 4'b0001);
    bus.p0_dir = '0;
    repeat (2) @(negedge clock);
    chk("t2_turn1", bus.turn, 1);

    // Turn timeout after 16 idle cycles, twice.
    repeat (15) @(negedge clock);
    chk("t3_no_to_yet", bus.timeout, 0);
    @(negedge clock);
    chk("t3_timeout", bus.timeout, 1);
    chk("t3_turn0", bus.turn, 0);
    chk("t3_count", bus.move_count, 3);
    repeat (15) @(negedge clock);
    chk("t3_turn_still0", bus.turn, 0);
    @(negedge clock);
    chk("t3_timeout2", bus.timeout, 1);
    chk("t3_turn1", bus.turn, 1);

    // Alternating moves until move_count saturates.
    for (int i = 0; i < 260; i++) begin
      press_active(4'(1 << (i % 4)));
      @(negedge clock);
      bus.p0_dir = '0;
      bus.p1_dir = '0;
      repeat (2) @(negedge clock);
    end
    chk("t6_saturated", bus.move_count, 255);

    // Asynchronous reset while an east pulse is out.
    press_active(4'b0010);
    @(posedge clock);
    #3;
    chk("t5_e_pulse", bus.e, 1);
    R_n = 1'b0;
    bus.p0_dir = '0;
    bus.p1_dir = '0;
    #1;
    chk("t5_e_killed", bus.e, 0);
    chk("t5_count0", bus.move_count, 0);
    chk("t5_turn0", bus.turn, 0);
    chk("t5_over0", bus.game_over, 0);
    @(negedge clock);
    R_n = 1'b1;
    bus.p0_dir = 4'b0100;
    @(negedge clock);
    chk("t5_s", {bus.n, bus.s, bus.e, bus.w}, 4'b0100);
    bus.p0_dir = '0;
    repeat (2) @(negedge clock);

    // Player 1 moves, then player 0's east move wins.
    bus.p1_dir = 4'b1000;
    @(negedge clock);
    bus.p1_dir = '0;
    repeat (2) @(negedge clock);
    bus.p0_dir = 4'b0010;
    @(negedge clock);
    chk("t4_e", {bus.n, bus.s, bus.e, bus.w}, 4'b0010);
    bus.p0_dir = '0;
    @(negedge clock);
    bus.win = 1'b1;
    @(negedge clock);
    bus.win = 1'b0;
    chk("t4_over", bus.game_over, 1);
    chk("t4_winner", bus.winner, 0);
    for (int i = 0; i < 20; i++) begin
      bus.p0_dir = 4'($urandom_range(0, 15));
      bus.p1_dir = 4'($urandom_range(0, 15));
      @(negedge clock);
      chk("t4_frozen", {bus.n, bus.s, bus.e, bus.w}, 4'b0000);
    end

    // Randomized play with occasional game end and reset.
    R_n = 1'b0;
    bus.p0_dir = '0;
    bus.p1_dir = '0;
    @(negedge clock);
    R_n = 1'b1;
    over_wait = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_over) over_wait++;
      if (over_wait > 6 || $urandom_range(0, 599) == 0) begin
        over_wait = 0;
        R_n = 1'b0;
        @(negedge clock);
        R_n = 1'b1;
      end
      bus.d   = ($urandom_range(0, 299) == 0);
      bus.win = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) bus.p0_dir = '0;
        else if (r < 8) bus.p0_dir = 4'(1 << (r - 4));
        else bus.p0_dir = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) bus.p1_dir = '0;
        else if (r < 8) bus.p1_dir = 4'(1 << (r - 4));
        else bus.p1_dir = 4'($urandom_range(0, 15));
      end
      @(negedge clock);
    end

    bus.d = 1'b0;
    bus.win = 1'b0;
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
